prefetcher_queue: RTL and testbench
===================================

Name: prefetcher_queue

Overview:
Parametrised successor to the single-entry serial instruction prefetcher. It keeps up to DEPTH instruction words, counting both stored and in-flight words, in a circular FIFO. It issues READ_16 commands over the serial TX interface, streaming the fetch address LSB-first, and collects words from the serial RX interface. It adds three things the previous block lacked: a parallel jump/redirect with tagged discard of stale in-flight responses, a head-PC output, and configurable depth and reset address. It sits between the serial bus controller and the instruction decoder.

Parameters:
IO_BITS, 2, serial pins per cycle
PAYLOAD_CYCLES, 8, cycles per 16-bit payload; WORD_BITS = IO_BITS*PAYLOAD_CYCLES
DEPTH, 4, maximum words stored plus in flight (≥1)
RESET_PC, 0, first fetch address after reset (bit 0 must be 0)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst  out  WORD_BITS  head-of-queue word
inst_valid  out  1  queue non-empty
inst_done  in  1  pop head (one word per cycle)
head_pc  out  WORD_BITS  address of inst
jump_valid  in  1  one-cycle redirect pulse
jump_addr  in  WORD_BITS  redirect target (bit 0 ignored, treated 0)
tx_command_valid  out  1  request to send a read command
tx_command  out  `TX_CMD_BITS  constant `TX_HEADER_READ_16
tx_command_started  in  1  bus accepted our command (one cycle)
tx_data  out  IO_BITS  address bits, LSB-first
tx_data_next  in  1  advance tx_data
tx_counter  in  $clog2(PAYLOAD_CYCLES)+1  payload cycle index
rx_data_valid  in  1  rx_pins hold our payload bits
rx_pins  in  IO_BITS  payload bits, LSB-first
rx_done  in  1  our response complete (one cycle, strictly after final rx_data_valid)

Behaviour:
- Counters are $clog2(DEPTH+1) wide:
  - occ: FIFO entries.
  - inflight: commands started whose rx_done has not arrived.
  - discard: in-flight responses to drop.
- Invariant: occ + inflight ≤ DEPTH; discard ≤ inflight.
- Reset values:
  - occ = inflight = discard = 0.
  - fetch_pc = head_pc = RESET_PC.
  - inst_valid = 0, tx_command_valid = 0 in the reset cycle; inst and tx_data are 0.
- tx_command_valid = (occ + inflight < DEPTH) && !jump_valid. This is combinational.
- On tx_command_started:
  - inflight++.
  - The address shift register loads fetch_pc.
  - fetch_pc += 2, wrapping mod 2^WORD_BITS.
- tx_data = address shift register [IO_BITS-1:0]. Each tx_data_next shifts right by IO_BITS.
- The address being transmitted is never altered by a later jump.
- Every rx_data_valid shifts rx_pins into the RX register MSB-side (LSB-first assembly).
- On rx_done, inflight-- and:
  - if discard > 0: discard--, word dropped;
  - else: the RX register is written at the FIFO tail and occ++.
- inst_done with inst_valid: head advances, occ--, head_pc += 2 (wrap). inst_done without inst_valid is ignored.
- Push and pop in the same cycle: occ unchanged. inst reflects the new head next cycle.
- Latency:
  - rx_done → inst_valid is 1 cycle when the queue was empty.
  - inst_done → next word on inst is 1 cycle.
- On jump_valid:
  - FIFO is cleared (occ = 0, head/tail pointers reset).
  - fetch_pc = head_pc = jump_addr & ~1.
  - discard = inflight after this cycle's updates, i.e. a same-cycle tx_command_started and rx_done are both counted.
  - A same-cycle inst_done is ignored.
  - A same-cycle rx_done is discarded, never pushed.
- Pointers wrap mod DEPTH and need not be a power of two. The FIFO cannot overflow, because the credit limit guarantees space.
- Reset mid-transaction clears all state. External TX/RX sequencing is reset by the same signal.

Test Plan:
- Fill from reset, DEPTH=4, responses 0x1111, 0x2222, 0x3333, 0x4444, no pops → four commands with serial addresses 0, 2, 4, 6. tx_command_valid drops after the 4th start. inst=0x1111, head_pc=0.
- Pop one word per cycle while refilling → inst sequence 1111, 2222, 3333, 4444 in order. head_pc 0, 2, 4, 6. The next command carries address 8.
- Jump to 0x0101 with 2 in flight and 1 stored → inst_valid=0 the next cycle. The next two rx_done are dropped. The next command sends 0x0100. head_pc=0x0100.
- Jump in the same cycle as rx_done and inst_done → the word is not pushed, the pop is ignored, and discard equals the remaining inflight.
- fetch_pc at 0xFFFE → next address 0x0000. With DEPTH=3, pointers wrap correctly over 10 push/pop pairs.
- Reset asserted mid-payload → next cycle inst_valid=0, tx_command_valid=1, and the next address sent is RESET_PC.

Source files
------------

// File: rtl/prefetcher_queue_if.sv
// Bus bundle between the prefetch queue, the serial bus controller and the decoder.
// master = prefetcher side, slave = controller/decoder side.
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 4
`endif
`ifndef TX_HEADER_READ_16
`define TX_HEADER_READ_16 4'h3
`endif

interface prefetcher_queue_if #(
   parameter int IO_BITS        = 2,
   parameter int PAYLOAD_CYCLES = 8
);
   localparam int WORD_BITS = IO_BITS * PAYLOAD_CYCLES;
   localparam int CNT_BITS  = $clog2(PAYLOAD_CYCLES) + 1;

   logic [WORD_BITS-1:0]    inst;
   logic                    inst_valid;
   logic                    inst_done;
   logic [WORD_BITS-1:0]    head_pc;
   logic                    jump_valid;
   logic [WORD_BITS-1:0]    jump_addr;
   logic                    tx_command_valid;
   logic [`TX_CMD_BITS-1:0] tx_command;
   logic                    tx_command_started;
   logic [IO_BITS-1:0]      tx_data;
   logic                    tx_data_next;
   logic [CNT_BITS-1:0]     tx_counter;
   logic                    rx_data_valid;
   logic [IO_BITS-1:0]      rx_pins;
   logic                    rx_done;

   modport master (
      output inst, inst_valid, head_pc, tx_command_valid, tx_command, tx_data,
      input  inst_done, jump_valid, jump_addr, tx_command_started, tx_data_next,
             tx_counter, rx_data_valid, rx_pins, rx_done
   );

   modport slave (
      input  inst, inst_valid, head_pc, tx_command_valid, tx_command, tx_data,
      output inst_done, jump_valid, jump_addr, tx_command_started, tx_data_next,
             tx_counter, rx_data_valid, rx_pins, rx_done
   );
endinterface

// File: rtl/prefetcher_queue.sv
// Credit-limited serial instruction prefetch FIFO with jump redirect; words already
// requested before a jump are counted in discard and dropped when they arrive.
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 4
`endif
`ifndef TX_HEADER_READ_16
`define TX_HEADER_READ_16 4'h3
`endif

module prefetcher_queue #(
   parameter int          IO_BITS        = 2,
   parameter int          PAYLOAD_CYCLES = 8,
   parameter int          DEPTH          = 4,
   parameter int unsigned RESET_PC       = 0
) (
   input  logic               clk,
   input  logic               reset,
   prefetcher_queue_if.master bus
);
   localparam int WORD_BITS = IO_BITS * PAYLOAD_CYCLES;
   localparam int CW        = $clog2(DEPTH + 1);
   localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WORD_BITS-1:0] PC_STEP  = WORD_BITS'(2);
   localparam logic [WORD_BITS-1:0] PC_RESET = WORD_BITS'(RESET_PC);

   logic [CW-1:0]        occ_q, occ_d, inflight_q, inflight_d, discard_q, discard_d;
   logic [PW-1:0]        head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d;
   logic [WORD_BITS-1:0] fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
   logic [WORD_BITS-1:0] addr_sr_q, addr_sr_d, rx_sr_q, rx_sr_d;
   logic [WORD_BITS-1:0] mem_q [DEPTH];
   logic                 push, pop, credit_ok, queue_valid;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      credit_ok   = ({1'b0, occ_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
      queue_valid = (occ_q != '0) && !reset;
      bus.tx_command_valid = credit_ok && !bus.jump_valid && !reset;
      bus.tx_command       = `TX_HEADER_READ_16;
      bus.tx_data          = addr_sr_q[IO_BITS-1:0];
      bus.inst_valid       = queue_valid;
      bus.inst             = queue_valid ? mem_q[head_ptr_q] : '0;
      bus.head_pc          = head_pc_q;
   end

   always_comb begin
      pop  = bus.inst_done && (occ_q != '0) && !bus.jump_valid;
      push = bus.rx_done && (discard_q == '0) && !bus.jump_valid;

      addr_sr_d  = addr_sr_q;
      fetch_pc_d = fetch_pc_q;
      rx_sr_d    = rx_sr_q;
      head_ptr_d = head_ptr_q;
      tail_ptr_d = tail_ptr_q;
      head_pc_d  = head_pc_q;
      discard_d  = discard_q;
      inflight_d = inflight_q + CW'(bus.tx_command_started) - CW'(bus.rx_done);
      occ_d      = occ_q + CW'(push) - CW'(pop);

      if (bus.tx_command_started) begin
         addr_sr_d  = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + PC_STEP;
      end else if (bus.tx_data_next) begin
         addr_sr_d = addr_sr_q >> IO_BITS;
      end

      if (bus.rx_data_valid)
         rx_sr_d = {bus.rx_pins, rx_sr_q[WORD_BITS-1:IO_BITS]};

      if (push) tail_ptr_d = ptr_inc(tail_ptr_q);
      if (pop) begin
         head_ptr_d = ptr_inc(head_ptr_q);
         head_pc_d  = head_pc_q + PC_STEP;
      end

      if (bus.rx_done && (discard_q != '0))
         discard_d = discard_q - CW'(1);

      // Redirect: everything still in flight after this cycle becomes stale.
      if (bus.jump_valid) begin
         occ_d      = '0;
         head_ptr_d = '0;
         tail_ptr_d = '0;
         fetch_pc_d = {bus.jump_addr[WORD_BITS-1:1], 1'b0};
         head_pc_d  = {bus.jump_addr[WORD_BITS-1:1], 1'b0};
         discard_d  = inflight_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q      <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
         head_ptr_q <= '0;
         tail_ptr_q <= '0;
         fetch_pc_q <= PC_RESET;
         head_pc_q  <= PC_RESET;
         addr_sr_q  <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         head_ptr_q <= head_ptr_d;
         tail_ptr_q <= tail_ptr_d;
         fetch_pc_q <= fetch_pc_d;
         head_pc_q  <= head_pc_d;
         addr_sr_q  <= addr_sr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[tail_ptr_q] <= rx_sr_q;
      rx_sr_q <= rx_sr_d;
   end
endmodule

// File: tb/tb_prefetcher_queue.sv
// Randomised bench for prefetcher_queue: a serial bus agent plus a queue-level model
// of stored words, pending requests (with stale flags) and the two program counters.
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 4
`endif
`ifndef TX_HEADER_READ_16
`define TX_HEADER_READ_16 4'h3
`endif

module tb_prefetcher_queue;
   localparam int          IO_BITS  = 2;
   localparam int          PC       = 8;
   localparam int          DEPTH    = 3;
   localparam int unsigned RESET_PC = 'h0040;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   prefetcher_queue_if #(.IO_BITS(IO_BITS), .PAYLOAD_CYCLES(PC)) bus ();

   prefetcher_queue #(.IO_BITS(IO_BITS), .PAYLOAD_CYCLES(PC), .DEPTH(DEPTH),
                      .RESET_PC(RESET_PC)) dut (.clk(clk), .reset(reset), .bus(bus));

   // Reference model
   logic [15:0] fifo[$];
   logic [15:0] p_addr[$];
   bit          p_drop[$];
   bit          p_txd[$];
   logic [15:0] m_head_pc, m_fetch_pc;

   // Bus agent state
   bit          tx_busy, rx_busy;
   int          tx_cnt, rx_cnt;
   logic [15:0] tx_acc, tx_exp, rx_word;

   // Knobs
   int          p_start, p_pop, p_jump, p_rxgo, jump_span;
   logic [15:0] jump_base, force_ja;
   bit          force_jv;

   int ncmp = 0;
   int nfail = 0;

   function automatic logic [15:0] resp(input logic [15:0] a);
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      fifo.delete(); p_addr.delete(); p_drop.delete(); p_txd.delete();
      m_head_pc = 16'(RESET_PC);
      m_fetch_pc = 16'(RESET_PC);
      tx_busy = 0; rx_busy = 0; tx_cnt = 0; rx_cnt = 0; tx_acc = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.inst_done = 0; bus.jump_valid = 0; bus.jump_addr = '0;
      bus.tx_command_started = 0; bus.tx_data_next = 0; bus.tx_counter = '0;
      bus.rx_data_valid = 0; bus.rx_pins = '0; bus.rx_done = 0;
      @(posedge clk); #1;
      check("rst_inst_valid", bus.inst_valid, 0);
      check("rst_tx_cmd_valid", bus.tx_command_valid, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_inst", bus.inst, 0);
      check("rst_head_pc", bus.head_pc, RESET_PC);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic cycle();
      bit st, tn, rv, rd, dn, jv, popok, drop;
      logic [15:0] ja;
      logic [IO_BITS-1:0] pins;
      rv = 0; rd = 0; pins = '0;
      if (rx_busy) begin
         if (rx_cnt < PC) begin
            rv = ($urandom_range(3) != 0);
            pins = rx_word[rx_cnt*IO_BITS +: IO_BITS];
         end else begin
            rd = $urandom_range(1) == 1;
         end
      end else if (p_addr.size() > 0 && p_txd[0] && $urandom_range(99) < p_rxgo) begin
         rx_busy = 1; rx_cnt = 0; rx_word = resp(p_addr[0]);
      end
      jv = ($urandom_range(99) < p_jump) || (rd && p_jump > 0 && $urandom_range(2) == 0);
      ja = jump_base + 16'($urandom_range(jump_span));
      if (force_jv) begin jv = 1; ja = force_ja; force_jv = 0; end
      st = ((fifo.size() + p_addr.size()) < DEPTH) && !jv && !tx_busy &&
           ($urandom_range(99) < p_start);
      tn = tx_busy && ($urandom_range(3) != 0);
      dn = ($urandom_range(99) < p_pop);

      bus.tx_command_started = st; bus.tx_data_next = tn; bus.tx_counter = 4'(tx_cnt);
      bus.rx_data_valid = rv; bus.rx_pins = pins; bus.rx_done = rd;
      bus.inst_done = dn; bus.jump_valid = jv; bus.jump_addr = ja;
      #3;
      check("tx_command_valid", bus.tx_command_valid,
            ((fifo.size() + p_addr.size()) < DEPTH) && !jv);
      check("inst_valid", bus.inst_valid, fifo.size() != 0);
      check("head_pc", bus.head_pc, m_head_pc);
      if (fifo.size() != 0) check("inst", bus.inst, fifo[0]);

      if (tn) begin
         tx_acc[tx_cnt*IO_BITS +: IO_BITS] = bus.tx_data;
         tx_cnt++;
         if (tx_cnt == PC) begin
            check("tx_addr", tx_acc, tx_exp);
            tx_busy = 0;
            p_txd[p_txd.size()-1] = 1;
         end
      end
      if (rv) rx_cnt++;

      popok = dn && fifo.size() != 0 && !jv;
      if (st) begin
         p_addr.push_back(m_fetch_pc); p_drop.push_back(0); p_txd.push_back(0);
         tx_exp = m_fetch_pc; tx_busy = 1; tx_cnt = 0;
         m_fetch_pc = m_fetch_pc + 16'd2;
      end
      if (popok) begin
         void'(fifo.pop_front());
         m_head_pc = m_head_pc + 16'd2;
      end
      if (rd) begin
         drop = p_drop[0] || jv;
         void'(p_addr.pop_front()); void'(p_drop.pop_front()); void'(p_txd.pop_front());
         if (!drop) fifo.push_back(rx_word);
         rx_busy = 0;
      end
      if (jv) begin
         fifo.delete();
         foreach (p_drop[i]) p_drop[i] = 1;
         m_fetch_pc = ja & 16'hFFFE;
         m_head_pc = ja & 16'hFFFE;
      end
      @(posedge clk); #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      force_jv = 0; jump_base = 16'h0100; jump_span = 0; force_ja = '0;
      do_reset();
      check("tx_command", bus.tx_command, `TX_HEADER_READ_16);

      // Fill with no pops, then drain while refilling
      p_start = 100; p_pop = 0; p_jump = 0; p_rxgo = 100;
      run(80);
      check("filled", bus.inst_valid, 1);
      p_pop = 60;
      run(300);

      // Frequent redirects, including odd targets and collisions with rx_done/inst_done
      p_jump = 6; p_pop = 50; jump_base = 16'h0100; jump_span = 'h40;
      run(700);

      // Address wrap past 0xFFFE for both fetch and head counters
      p_jump = 0; force_jv = 1; force_ja = 16'hFFF9;
      run(300);

      // Reset mid-payload, then a long mixed run
      for (int i = 0; i < 200 && !(tx_busy && tx_cnt > 2); i++) cycle();
      check("reach_midpayload", tx_busy && tx_cnt > 2, 1);
      do_reset();
      p_start = 100; p_pop = 0;
      run(40);
      p_start = 70; p_pop = 40; p_jump = 3; p_rxgo = 60; jump_base = 16'hFFF0; jump_span = 'h20;
      run(1500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
